// File: rtl/alu_resp_unit.sv
// alu_resp_unit
// ---------------------------------------------------------------------------
// Purpose:
//   This block is a single-cycle ALU with a small in-order response buffer.
//   On the edge that accepts a request, the result is computed combinationally
//   from the request inputs and pushed into a DEPTH-entry FIFO. The FIFO head
//   is shown on the rsp_* outputs. A 16-bit counter tracks delivered responses.
//
// Handshake:
//   A transfer on either side happens on a rising edge where valid=1 and
//   ready=1. The producer holds its payload stable while valid=1 and ready=0.
//   While rsp_valid=1 and rsp_ready=0, the head fields do not change.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request can be accepted this cycle
//   req_a      in   W   operand a
//   req_b      in   W   operand b
//   req_op     in   3   000 AND, 001 OR, 010 ADD, 110 SUB, others illegal
//   rsp_valid  out  1   FIFO non-empty
//   rsp_ready  in   1   consumer takes head response
//   rsp_z      out  W   head result (0 while empty)
//   rsp_ex     out  1   head zero flag (0 while empty)
//   rsp_err    out  1   head illegal-opcode flag (0 while empty)
//   txn_count  out  16  responses delivered since reset, wraps
// ---------------------------------------------------------------------------
module alu_resp_unit #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [2:0]   req_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_z,
    output logic         rsp_ex,
    output logic         rsp_err,
    output logic [15:0]  txn_count
);

    // Pointer width: at least 1 bit so that DEPTH=1 still elaborates.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The occupancy counter must be able to hold the value DEPTH itself.
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] L_LAST  = PW'(DEPTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    // Control state
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_txn_count;

    // Data storage (not reset)
    logic [W-1:0]  r_mem_z   [DEPTH];
    logic          r_mem_ex  [DEPTH];
    logic          r_mem_err [DEPTH];

    logic [W-1:0]  w_z;
    logic          w_err;
    logic          w_ex;
    logic          w_not_empty;
    logic          w_push;
    logic          w_pop;

    // ALU datapath
    always_comb begin
        w_z   = '0;
        w_err = 1'b0;
        case (req_op)
            OP_AND:  w_z = req_a & req_b;
            OP_OR:   w_z = req_a | req_b;
            OP_ADD:  w_z = req_a + req_b;
            OP_SUB:  w_z = req_a + ~req_b + W'(1);
            default: begin
                w_z   = '0;
                w_err = 1'b1;
            end
        endcase
    end

    assign w_ex = (w_z == '0);

    // Handshake
    assign w_not_empty = (r_count != '0);
    // A full buffer can still take a request when the head leaves on the same edge.
    assign req_ready   = rst_n & ((r_count < L_DEPTH) | rsp_ready);
    assign w_pop       = w_not_empty & rsp_ready;
    assign w_push      = req_valid & req_ready;

    // Control state update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_txn_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + PW'(1);
                r_txn_count <= r_txn_count + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tail write. w_push is already qualified by rst_n through req_ready.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_z[r_wr_ptr]   <= w_z;
            r_mem_ex[r_wr_ptr]  <= w_ex;
            r_mem_err[r_wr_ptr] <= w_err;
        end
    end

    // Head outputs. They are gated so an empty buffer always reads as zero.
    assign rsp_valid = w_not_empty;
    assign rsp_z     = w_not_empty ? r_mem_z[r_rd_ptr]   : '0;
    assign rsp_ex    = w_not_empty ? r_mem_ex[r_rd_ptr]  : 1'b0;
    assign rsp_err   = w_not_empty ? r_mem_err[r_rd_ptr] : 1'b0;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_alu_resp_unit.sv
module tb_alu_resp_unit;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_z;
    logic         rsp_ex;
    logic         rsp_err;
    logic [15:0]  txn_count;

    alu_resp_unit #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_ex    (rsp_ex),
        .rsp_err   (rsp_err),
        .txn_count (txn_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int n_push = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each entry is {err, ex, z}.
    logic [W+1:0] exp_q[$];
    logic [15:0]  exp_cnt;

    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        logic [W-1:0] z;
        logic         err;
        err = 1'b0;
        case (op)
            3'd0:    z = a & b;
            3'd1:    z = a | b;
            3'd2:    z = a + b;
            3'd6:    z = a - b;
            default: begin z = '0; err = 1'b1; end
        endcase
        return {err, (z == '0), z};
    endfunction

    // The model advances on the same edge as the DUT, using only the bench inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 16'd0;
        end else begin
            bit pop;
            bit push;
            logic [W+1:0] ent;
            ent  = ref_op(req_a, req_b, req_op);
            pop  = (exp_q.size() > 0) && rsp_ready;
            push = req_valid && ((exp_q.size() < DEPTH) || pop);
            if (pop) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (push) begin
                exp_q.push_back(ent);
                n_push++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [W+1:0] head;
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
            chk("rsp_z",     64'(rsp_z),     64'(head[W-1:0]));
            chk("rsp_ex",    64'(rsp_ex),    64'(head[W]));
            chk("rsp_err",   64'(rsp_err),   64'(head[W+1]));
            chk("txn_count", 64'(txn_count), 64'(exp_cnt));
            chk("req_ready", 64'(req_ready),
                64'(rst_n && ((exp_q.size() < DEPTH) || rsp_ready)));
        end
    end

    // ---------------- driver tasks ----------------
    // Each task starts and ends 1 time unit after a rising edge.
    task automatic drive_idle();
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 3'd0;
    endtask

    // This task pushes one request into an empty buffer and checks the head
    // against literal values. It then pops that head.
    task automatic one_shot(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                            input logic [W-1:0] ez, input logic eex, input logic eerr,
                            input string tag);
        rsp_ready = 1'b0;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_z"},     64'(rsp_z),     64'(ez));
        chk({tag, "_ex"},    64'(rsp_ex),    64'(eex));
        chk({tag, "_err"},   64'(rsp_err),   64'(eerr));
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int target;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_txn",   64'(txn_count), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_z",     64'(rsp_z),     64'd0);
        @(posedge clk); #1;

        // 5 + 3 with rsp_ready=1, one-cycle latency, then delivery
        rsp_ready = 1'b1;
        req_a = 32'd5; req_b = 32'd3; req_op = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("add_valid", 64'(rsp_valid), 64'd1);
        chk("add_z",     64'(rsp_z),     64'd8);
        chk("add_ex",    64'(rsp_ex),    64'd0);
        chk("add_err",   64'(rsp_err),   64'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("add_txn",   64'(txn_count), 64'd1);
        chk("add_empty", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Literal operation pins
        one_shot(32'hFFFFFFFF, 32'd1, 3'b010, 32'h0, 1'b1, 1'b0, "add_wrap");
        one_shot(32'd3, 32'd5, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, "sub");
        one_shot(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0, "and");
        one_shot(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0, "or");
        one_shot(32'd7, 32'd9, 3'b011, 32'h0, 1'b1, 1'b1, "illegal");
        one_shot(32'd9, 32'd9, 3'b110, 32'h0, 1'b1, 1'b0, "sub_zero");

        // Full-buffer backpressure: three requests, DEPTH=2
        rsp_ready = 1'b0;
        req_op = 3'b001; req_b = '0; req_a = 32'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_a = 32'd2;
        @(posedge clk); #1;
        req_a = 32'd3;
        @(negedge clk);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_head",  64'(rsp_z),     64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_hold_ready", 64'(req_ready), 64'd0);
        chk("full_hold_head",  64'(rsp_z),     64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        #1 chk("pop_frees_slot", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("order_2", 64'(rsp_z), 64'd2);
        @(negedge clk);
        chk("order_3", 64'(rsp_z), 64'd3);
        @(negedge clk);
        chk("order_empty", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Reset while holding two entries; the request in the reset cycle is dropped
        rsp_ready = 1'b0;
        req_op = 3'b010; req_a = 32'd10; req_b = 32'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_a = 32'd20;
        @(posedge clk); #1;
        req_a = 32'd30;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();
        @(negedge clk);
        chk("rst_flush_valid", 64'(rsp_valid), 64'd0);
        chk("rst_flush_txn",   64'(txn_count), 64'd0);
        #1 rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;

        // txn_count rollover: first edge only pushes, then one delivery per edge
        rsp_ready = 1'b1;
        req_op = 3'b000; req_a = 32'hA5A5A5A5; req_b = 32'hFFFF0000; req_valid = 1'b1;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        chk("txn_ffff", 64'(txn_count), 64'h0000_0000_0000_FFFF);
        @(negedge clk);
        chk("txn_wrap", 64'(txn_count), 64'd0);
        #1 drive_idle();
        @(posedge clk); #1;

        // Randomized traffic
        target = n_push + 200;
        cyc = 0;
        while (n_push < target && cyc < 4000) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_op    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       begin req_a = '0;          req_b = 32'($urandom); end
                1:       begin req_a = 32'hFFFFFFFF; req_b = 32'($urandom_range(0, 2)); end
                2:       begin req_a = 32'($urandom); req_b = req_a; end
                default: begin req_a = 32'($urandom); req_b = 32'($urandom); end
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_budget", 64'(n_push >= target), 64'd1);
        drive_idle();

        // Drain
        rsp_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(rsp_valid), 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
